// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared constants and helpers for the arbitrated select stage
//               and other arbiters: mode encodings, a constant-foldable
//               ceil(log2) and an index-to-onehot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    localparam int MODE_SEL   = 0;   // external channel select
    localparam int MODE_RR    = 1;   // round-robin among valid channels
    localparam int ONEHOT_MAX = 16;  // widest channel count any arbiter uses

    // ceil(log2(n)); usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Decode an index into a onehot vector; callers truncate to their width.
    function automatic logic [ONEHOT_MAX-1:0] idx_to_onehot(input logic [3:0] idx);
        return ONEHOT_MAX'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Returns the first
//               requesting index found when searching ptr, ptr+1, ...
//               with wrap-around modulo NCH.
// Ports       : req     in  NCH   request vector
//               ptr     in  SELW  highest-priority index (must be < NCH)
//               gnt_vld out 1     at least one request present
//               gnt_idx out SELW  granted index (0 when gnt_vld=0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic [2*NCH-1:0] w_req2;
    logic [NCH-1:0]   w_rot;
    int               w_sum;

    // Rotating the doubled vector right by ptr puts channel ptr at bit 0, so
    // the lowest set bit of w_rot is the distance from ptr to the winner.
    assign w_req2 = {req, req};
    assign w_rot  = NCH'(w_req2 >> ptr);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_sum   = 0;
        // Scan from the far end so the nearest request is written last.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(ptr) + k;
                if (w_sum >= NCH) begin
                    w_sum = w_sum - NCH;
                end
                gnt_vld = 1'b1;
                gnt_idx = SELW'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pipe
// Description : N-channel, DW-bit select stage with a single output register
//               and valid/ready handshakes on every input and on the output.
//               MODE=MODE_SEL picks the channel named by sel; MODE=MODE_RR
//               picks round-robin among valid channels.
// Ports       : clk       in  1       clock, rising edge
//               rst_n     in  1       async reset, active-low
//               in_valid  in  NCH     per-channel valid
//               in_data   in  NCH*DW  channel i at [i*DW +: DW]
//               in_ready  out NCH     per-channel ready (at most one high)
//               sel       in  SELW    channel select (MODE_SEL only)
//               out_valid out 1       output register holds a word
//               out_data  out DW      registered data
//               out_grant out SELW    source channel of the held word
//               out_ready in  1       consumer accepts the word
// Macro       : ARB_MUX_PIPE_SKID_EN - adds a skid register so in_ready is
//               driven from registered state only (no out_ready->in_ready
//               path). Undefined by default.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_pipe
    import arb_mux_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_SEL,
    localparam int SELW = clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    input  logic [SELW-1:0]   sel,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SELW-1:0]   out_grant,
    input  logic              out_ready
);

    logic            w_gnt_vld;
    logic [SELW-1:0] w_gnt_idx;
    logic [NCH-1:0]  w_gnt_oh;
    logic            w_gnt_in_valid;
    logic [DW-1:0]   w_gnt_in_data;
    logic            w_load_en;
    logic            w_accept_en;
    logic            w_xfer;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic [SELW-1:0] out_grant_q, out_grant_d;

    // ------------------------------------------------------------------
    // Channel choice
    // ------------------------------------------------------------------
    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr_q, ptr_d;
            logic            w_unused_sel;

            assign w_unused_sel = ^sel;

            rr_pick #(.NCH(NCH)) u_rr_pick (
                .req     (in_valid),
                .ptr     (ptr_q),
                .gnt_vld (w_gnt_vld),
                .gnt_idx (w_gnt_idx)
            );

            // Pointer moves past the winner only on an actual input transfer.
            always_comb begin
                ptr_d = ptr_q;
                if (w_xfer) begin
                    ptr_d = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_sel
            // Out-of-range selects (non-power-of-two NCH) grant nothing.
            assign w_gnt_vld = (int'(sel) < NCH);
            assign w_gnt_idx = sel;
        end
    endgenerate

    assign w_gnt_oh = NCH'(idx_to_onehot(4'(w_gnt_idx)));

    always_comb begin
        w_gnt_in_valid = 1'b0;
        w_gnt_in_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_in_valid = in_valid[i];
                w_gnt_in_data  = in_data[i*DW +: DW];
            end
        end
    end

    assign w_load_en = !out_valid_q || out_ready;
    assign w_xfer    = w_accept_en && w_gnt_vld && w_gnt_in_valid;
    // rst_n gates in_ready so producers never see a handshake during reset.
    assign in_ready  = (rst_n && w_accept_en && w_gnt_vld) ? w_gnt_oh : '0;

`ifdef ARB_MUX_PIPE_SKID_EN
    // ------------------------------------------------------------------
    // Skid variant: inputs are accepted whenever the skid slot is empty.
    // A word arriving while the output is full and stalled parks in skid;
    // the output always drains skid before taking a fresh input word.
    // ------------------------------------------------------------------
    logic            skid_valid_q, skid_valid_d;
    logic [DW-1:0]   skid_data_q,  skid_data_d;
    logic [SELW-1:0] skid_grant_q, skid_grant_d;

    assign w_accept_en = !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_grant_d  = out_grant_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_grant_d = skid_grant_q;
        if (w_load_en) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_grant_d  = skid_grant_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_xfer;
                if (w_xfer) begin
                    out_data_d  = w_gnt_in_data;
                    out_grant_d = w_gnt_idx;
                end
            end
        end else if (w_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = w_gnt_in_data;
            skid_grant_d = w_gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_grant_q <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_grant_q <= skid_grant_d;
        end
    end
`else
    assign w_accept_en = w_load_en;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        if (w_load_en) begin
            out_valid_d = w_xfer;
            if (w_xfer) begin
                out_data_d  = w_gnt_in_data;
                out_grant_d = w_gnt_idx;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

endmodule
`default_nettype wire
